winograd_tile_scheduler: RTL

WINOGRAD_TILE_SCHEDULER -- requirements
Module: winograd_tile_scheduler

---
 rtl/winograd_tile_scheduler_if.sv | 34 +++
 rtl/winograd_tile_scheduler.sv | 129 ++++++++++++
 2 files changed

// File: rtl/winograd_tile_scheduler_if.sv
// Scheduler-side bundle: frame config, memory read port, transform-unit handshake
// and downstream tile output.
interface winograd_tile_scheduler_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic                                start;
    logic [ADDR_W-1:0]                   base_addr;
    logic [ADDR_W-1:0]                   row_stride;
    logic [5:0]                          tiles_h;
    logic [5:0]                          tiles_w;
    logic                                mem_rd_en;
    logic [ADDR_W-1:0]                   mem_rd_addr;
    logic [DATA_W-1:0]                   mem_rd_data;
    logic [0:5][0:5][DATA_W-1:0]         tile_buf;
    logic                                ttu_start;
    logic                                ttu_done;
    logic                                out_valid;
    logic                                out_ready;
    logic [5:0]                          tile_row;
    logic [5:0]                          tile_col;
    logic                                busy;
    logic                                done;

    modport master (
        input  start, base_addr, row_stride, tiles_h, tiles_w, mem_rd_data, ttu_done, out_ready,
        output mem_rd_en, mem_rd_addr, tile_buf, ttu_start, out_valid, tile_row, tile_col, busy, done
    );

    modport slave (
        output start, base_addr, row_stride, tiles_h, tiles_w, mem_rd_data, ttu_done, out_ready,
        input  mem_rd_en, mem_rd_addr, tile_buf, ttu_start, out_valid, tile_row, tile_col, busy, done
    );
endinterface

// File: rtl/winograd_tile_scheduler.sv
// Walks a frame of overlapping 6x6 tiles (stride 4), fetches each into tile_buf,
// kicks the transform unit and hands the tile downstream.
module winograd_tile_scheduler #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    winograd_tile_scheduler_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, XFORM, WAIT, OUTPUT, FIN} state_t;

    state_t                      state, state_d;
    logic [ADDR_W-1:0]           cfg_base, cfg_stride;
    logic [5:0]                  cfg_th, cfg_tw;
    logic [5:0]                  tile_row, tile_col;
    logic [2:0]                  fi, fj;
    logic                        rd_vld;
    logic [2:0]                  wi, wj;
    logic [0:5][0:5][DATA_W-1:0] tile_buf;
    logic                        rd_en, ttu_start, out_valid, busy, done;
    logic                        last_elem, last_col, last_row;
    logic [ADDR_W-1:0]           row_idx, rd_addr;

    assign last_elem = (fi == 3'd5) && (fj == 3'd5);
    assign last_col  = (tile_col == cfg_tw - 6'd1);
    assign last_row  = (tile_row == cfg_th - 6'd1);

    // Tiles advance by 4 in both directions, so neighbours share a 2-element border.
    assign row_idx = ADDR_W'({tile_row, 2'b00}) + ADDR_W'(fi);
    assign rd_addr = cfg_base + row_idx * cfg_stride + ADDR_W'({tile_col, 2'b00}) + ADDR_W'(fj);

    always_comb begin
        state_d   = state;
        rd_en     = 1'b0;
        ttu_start = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.start)
                    state_d = (bus.tiles_h == 6'd0 || bus.tiles_w == 6'd0) ? FIN : FETCH;
            end
            FETCH: begin
                rd_en = 1'b1;
                if (last_elem) state_d = DRAIN;
            end
            DRAIN: state_d = XFORM;
            XFORM: begin
                ttu_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: if (bus.ttu_done) state_d = OUTPUT;
            OUTPUT: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = (last_col && last_row) ? FIN : FETCH;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_base   <= '0;
            cfg_stride <= '0;
            cfg_th     <= '0;
            cfg_tw     <= '0;
            tile_row   <= '0;
            tile_col   <= '0;
            fi         <= '0;
            fj         <= '0;
            rd_vld     <= 1'b0;
            wi         <= '0;
            wj         <= '0;
            tile_buf   <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                cfg_base   <= bus.base_addr;
                cfg_stride <= bus.row_stride;
                cfg_th     <= bus.tiles_h;
                cfg_tw     <= bus.tiles_w;
                tile_row   <= '0;
                tile_col   <= '0;
            end
            // Read data lags the strobe by one cycle; remember where it lands.
            rd_vld <= rd_en;
            wi     <= fi;
            wj     <= fj;
            if (rd_en) begin
                if (fj == 3'd5) begin
                    fj <= '0;
                    fi <= (fi == 3'd5) ? 3'd0 : fi + 3'd1;
                end else begin
                    fj <= fj + 3'd1;
                end
            end
            if (rd_vld) tile_buf[wi][wj] <= bus.mem_rd_data;
            if (state == OUTPUT && bus.out_ready) begin
                if (last_col) begin
                    tile_col <= '0;
                    tile_row <= last_row ? 6'd0 : tile_row + 6'd1;
                end else begin
                    tile_col <= tile_col + 6'd1;
                end
            end
        end
    end

    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = rd_en ? rd_addr : '0;
    assign bus.tile_buf    = tile_buf;
    assign bus.ttu_start   = ttu_start;
    assign bus.out_valid   = out_valid;
    assign bus.tile_row    = tile_row;
    assign bus.tile_col    = tile_col;
    assign bus.busy        = busy;
    assign bus.done        = done;
endmodule
